// File: rtl/hssi_rst_seq_csr.sv
`default_nettype none
// ============================================================================
// Module   : hssi_rst_seq_csr
// Brief    : HSSI per-channel reset sequencer behind a 64-bit CSR block.
//            Optional FORCE_RST direct override built when HSSI_RST_SEQ_FORCE_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hssi_rst_seq_csr #(
   parameter int NUM_CH      = 16,
   parameter int ADDR_WIDTH  = 11,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csr_write,
   input  logic [ADDR_WIDTH-1:0] csr_waddr,
   input  logic [63:0]           csr_wdata,
   input  logic                  csr_read,
   input  logic [ADDR_WIDTH-1:0] csr_raddr,
   output logic [63:0]           csr_readdata,
   output logic                  csr_readdata_valid,
   output logic [NUM_CH-1:0]     o_axis_tx_areset,
   output logic [NUM_CH-1:0]     o_axis_rx_areset,
   output logic [NUM_CH-1:0]     o_tx_rst,
   output logic [NUM_CH-1:0]     o_rx_rst,
   input  logic [NUM_CH-1:0]     i_tx_rst_ack,
   input  logic [NUM_CH-1:0]     i_rx_rst_ack,
   input  logic [NUM_CH-1:0]     i_tx_pll_locked,
   input  logic [NUM_CH-1:0]     i_rx_pcs_ready
);

   localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int c_TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int c_IDX_W = ADDR_WIDTH - 3;

   localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(ACK_TIMEOUT);

   localparam logic [c_IDX_W-1:0] c_A_REQ     = c_IDX_W'(0);
   localparam logic [c_IDX_W-1:0] c_A_DONE    = c_IDX_W'(1);
   localparam logic [c_IDX_W-1:0] c_A_TMO     = c_IDX_W'(2);
   localparam logic [c_IDX_W-1:0] c_A_SEQ     = c_IDX_W'(3);
   localparam logic [c_IDX_W-1:0] c_A_STATUS  = c_IDX_W'(4);
   localparam logic [c_IDX_W-1:0] c_A_SCRATCH = c_IDX_W'(5);
`ifdef HSSI_RST_SEQ_FORCE_EN
   localparam logic [c_IDX_W-1:0] c_A_FORCE   = c_IDX_W'(6);
`endif

   localparam logic [2:0] c_ST_IDLE         = 3'd0;
   localparam logic [2:0] c_ST_AXIS_ASSERT  = 3'd1;
   localparam logic [2:0] c_ST_RST_ASSERT   = 3'd2;
   localparam logic [2:0] c_ST_RST_RELEASE  = 3'd3;
   localparam logic [2:0] c_ST_AXIS_RELEASE = 3'd4;

   function automatic logic [31:0] pad32(input logic [NUM_CH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[NUM_CH-1:0] = v;
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [c_CH_W-1:0] idx);
      logic [NUM_CH-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   function automatic logic [c_CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      logic [c_CH_W-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) r = c_CH_W'(i);
      end
      return r;
   endfunction

   logic [2:0]         state_q, state_d;
   logic [c_CH_W-1:0]  ch_q, ch_d;
   logic [c_TMR_W-1:0] timer_q, timer_d;
   logic [NUM_CH-1:0]  axis_q, axis_d;
   logic [NUM_CH-1:0]  rst_q, rst_d;
   logic [NUM_CH-1:0]  pending_q, pending_d;
   logic [NUM_CH-1:0]  done_q, done_d;
   logic [NUM_CH-1:0]  tmo_q, tmo_d;
   logic [63:0]        scratch_q, scratch_d;
   logic [63:0]        rdata_q, rdata_d;
   logic               rvalid_q;
`ifdef HSSI_RST_SEQ_FORCE_EN
   logic [NUM_CH-1:0]  force_tx_q, force_tx_d;
   logic [NUM_CH-1:0]  force_rx_q, force_rx_d;
`endif

   logic               w_launch;
   logic [NUM_CH-1:0]  w_set_done;
   logic [NUM_CH-1:0]  w_set_tmo;
   logic               w_tx_ack;
   logic               w_rx_ack;
   logic [c_IDX_W-1:0] w_widx;
   logic [c_IDX_W-1:0] w_ridx;
   logic [NUM_CH-1:0]  w_wmask;
   logic               w_unused_addr_lsb;

   assign w_widx            = csr_waddr[ADDR_WIDTH-1:3];
   assign w_ridx            = csr_raddr[ADDR_WIDTH-1:3];
   assign w_wmask           = csr_wdata[NUM_CH-1:0];
   assign w_tx_ack          = i_tx_rst_ack[ch_q];
   assign w_rx_ack          = i_rx_rst_ack[ch_q];
   assign w_unused_addr_lsb = ^{csr_waddr[2:0], csr_raddr[2:0]};

   // Sequencer state register; outputs are registered from the next-state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_ST_IDLE;
         ch_q    <= '0;
         timer_q <= '0;
         axis_q  <= '0;
         rst_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         timer_q <= timer_d;
         axis_q  <= axis_d;
         rst_q   <= rst_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      timer_d    = timer_q;
      w_launch   = 1'b0;
      w_set_done = '0;
      w_set_tmo  = '0;
      case (state_q)
         c_ST_IDLE: begin
            if (|pending_q) begin
               ch_d     = lowest_set(pending_q);
               w_launch = 1'b1;
               state_d  = c_ST_AXIS_ASSERT;
            end
         end
         c_ST_AXIS_ASSERT: begin
            timer_d = '0;
            state_d = c_ST_RST_ASSERT;
         end
         c_ST_RST_ASSERT: begin
            if (w_tx_ack && w_rx_ack) begin
               timer_d = '0;
               state_d = c_ST_RST_RELEASE;
            end else if (timer_q == c_TMR_MAX) begin
               w_set_tmo = onehot(ch_q);
               state_d   = c_ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         c_ST_RST_RELEASE: begin
            if (!w_tx_ack && !w_rx_ack) begin
               state_d = c_ST_AXIS_RELEASE;
            end else if (timer_q == c_TMR_MAX) begin
               w_set_tmo = onehot(ch_q);
               state_d   = c_ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         c_ST_AXIS_RELEASE: begin
            w_set_done = onehot(ch_q);
            state_d    = c_ST_IDLE;
         end
         default: state_d = c_ST_IDLE;
      endcase
   end

   // AXI-S resets cover every non-idle state; PHY resets only RST_ASSERT.
   always_comb begin
      axis_d = '0;
      rst_d  = '0;
      if (state_d != c_ST_IDLE) axis_d = onehot(ch_d);
      if (state_d == c_ST_RST_ASSERT) rst_d = onehot(ch_d);
   end

   always_comb begin
      pending_d = pending_q;
      if (w_launch) pending_d = pending_d & ~onehot(ch_d);
      if (csr_write && (w_widx == c_A_REQ)) pending_d = pending_d | w_wmask;

      // Hardware set is applied after W1C so it wins a same-cycle collision.
      done_d = done_q;
      if (csr_write && (w_widx == c_A_DONE)) done_d = done_d & ~w_wmask;
      done_d = done_d | w_set_done;

      tmo_d = tmo_q;
      if (csr_write && (w_widx == c_A_TMO)) tmo_d = tmo_d & ~w_wmask;
      tmo_d = tmo_d | w_set_tmo;

      scratch_d = scratch_q;
      if (csr_write && (w_widx == c_A_SCRATCH)) scratch_d = csr_wdata;
`ifdef HSSI_RST_SEQ_FORCE_EN
      force_tx_d = force_tx_q;
      force_rx_d = force_rx_q;
      if (csr_write && (w_widx == c_A_FORCE)) begin
         force_tx_d = csr_wdata[NUM_CH-1:0];
         force_rx_d = csr_wdata[NUM_CH+31:32];
      end
`endif
   end

   always_comb begin
      rdata_d = '0;
      if (csr_read) begin
         case (w_ridx)
            c_A_REQ:     rdata_d = {32'h0, pad32(pending_q)};
            c_A_DONE:    rdata_d = {32'h0, pad32(done_q)};
            c_A_TMO:     rdata_d = {32'h0, pad32(tmo_q)};
            c_A_SEQ: begin
               rdata_d[2:0]  = state_q;
               rdata_d[12:8] = 5'(ch_q);
               rdata_d[16]   = (state_q != c_ST_IDLE);
            end
            c_A_STATUS:  rdata_d = {pad32(i_rx_pcs_ready), pad32(i_tx_pll_locked)};
            c_A_SCRATCH: rdata_d = scratch_q;
`ifdef HSSI_RST_SEQ_FORCE_EN
            c_A_FORCE:   rdata_d = {pad32(force_rx_q), pad32(force_tx_q)};
`endif
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         done_q     <= '0;
         tmo_q      <= '0;
         scratch_q  <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
`ifdef HSSI_RST_SEQ_FORCE_EN
         force_tx_q <= '0;
         force_rx_q <= '0;
`endif
      end else begin
         pending_q  <= pending_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
         scratch_q  <= scratch_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= csr_read;
`ifdef HSSI_RST_SEQ_FORCE_EN
         force_tx_q <= force_tx_d;
         force_rx_q <= force_rx_d;
`endif
      end
   end

   assign csr_readdata       = rdata_q;
   assign csr_readdata_valid = rvalid_q;
   assign o_axis_tx_areset   = axis_q;
   assign o_axis_rx_areset   = axis_q;
`ifdef HSSI_RST_SEQ_FORCE_EN
   assign o_tx_rst           = rst_q | force_tx_q;
   assign o_rx_rst           = rst_q | force_rx_q;
`else
   assign o_tx_rst           = rst_q;
   assign o_rx_rst           = rst_q;
`endif

endmodule
`default_nettype wire
